// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter
// Hands the shared tristate memory bus to either the CPU or one of NUM_CH DMA
// channels. Channel priority is fixed (index 0 highest). Ownership only changes
// when no memory access is in flight, a channel is only displaced at the end of
// one of its read+write units, and every hand-over passes through TURN_CYCLES
// dead cycles so that two bus drivers can never overlap.
// All outputs come straight from flops so the bus enables are glitch-free.

module dma_bus_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int TURN_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_dma_req,
    input  logic [NUM_CH-1:0] i_dma_boundary,
    input  logic              i_mem_wait,
    output logic [NUM_CH-1:0] o_dma_grant,
    output logic              o_cpu_grant,
    output logic              o_bus_idle,
    output logic [2:0]        o_owner_id,
    output logic              o_preempt_pulse
);

    // owner_id carries a 2-bit channel index; narrower configurations are
    // zero-extended into it.
    localparam int IDX_W = 2;

    // Last value of the 3-bit turnaround counter; TURN ends on this count.
    localparam logic [2:0] TURN_LAST = 3'(TURN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_CPU_OWN = 2'd0,
        ST_TURN    = 2'd1,
        ST_DMA_OWN = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_turn_cnt;
    logic [IDX_W-1:0] r_owner;

    logic [IDX_W-1:0]  w_winner;
    logic              w_any_req;
    logic [NUM_CH-1:0] w_winner_onehot;
    logic              w_higher_req;
    logic              w_owner_req;
    logic              w_owner_boundary;
    logic              w_turn_done;

    // Pick the lowest-index requesting channel; scanning downwards lets the
    // lowest index overwrite any higher one.
    always_comb begin
        w_winner  = '0;
        w_any_req = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (i_dma_req[k]) begin
                w_winner  = IDX_W'(k);
                w_any_req = 1'b1;
            end
        end
    end

    // One-hot form of the winner, loaded into the grant register on a hand-over.
    always_comb begin
        w_winner_onehot = '0;
        if (w_any_req) begin
            w_winner_onehot[w_winner] = 1'b1;
        end
    end

    // Does any channel with higher priority than the current owner want the bus?
    always_comb begin
        w_higher_req = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (IDX_W'(k) < r_owner) begin
                w_higher_req = w_higher_req | i_dma_req[k];
            end
        end
    end

    // Only the owning channel's request and boundary steer the DMA_OWN state.
    always_comb begin
        w_owner_req      = i_dma_req[r_owner];
        w_owner_boundary = i_dma_boundary[r_owner];
        w_turn_done      = (r_turn_cnt == TURN_LAST);
    end

    // Ownership state machine with registered bus-enable outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= ST_TURN;
            r_turn_cnt      <= 3'd0;
            r_owner         <= '0;
            o_dma_grant     <= '0;
            o_cpu_grant     <= 1'b0;
            o_bus_idle      <= 1'b1;
            o_owner_id      <= 3'b000;
            o_preempt_pulse <= 1'b0;
        end else begin
            o_preempt_pulse <= 1'b0;
            case (r_state)
                ST_CPU_OWN: begin
                    if (!i_mem_wait && w_any_req) begin
                        r_state     <= ST_TURN;
                        r_turn_cnt  <= 3'd0;
                        o_cpu_grant <= 1'b0;
                        o_bus_idle  <= 1'b1;
                    end
                end

                ST_TURN: begin
                    if (w_turn_done) begin
                        r_turn_cnt <= 3'd0;
                        o_bus_idle <= 1'b0;
                        if (w_any_req) begin
                            r_state     <= ST_DMA_OWN;
                            r_owner     <= w_winner;
                            o_dma_grant <= w_winner_onehot;
                            o_owner_id  <= {1'b1, w_winner};
                        end else begin
                            r_state     <= ST_CPU_OWN;
                            o_cpu_grant <= 1'b1;
                        end
                    end else begin
                        r_turn_cnt <= r_turn_cnt + 3'd1;
                    end
                end

                ST_DMA_OWN: begin
                    if (!i_mem_wait) begin
                        if (!w_owner_req) begin
                            r_state     <= ST_TURN;
                            r_turn_cnt  <= 3'd0;
                            o_dma_grant <= '0;
                            o_owner_id  <= 3'b000;
                            o_bus_idle  <= 1'b1;
                        end else if (w_owner_boundary && w_higher_req) begin
                            r_state         <= ST_TURN;
                            r_turn_cnt      <= 3'd0;
                            o_dma_grant     <= '0;
                            o_owner_id      <= 3'b000;
                            o_bus_idle      <= 1'b1;
                            o_preempt_pulse <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state     <= ST_TURN;
                    r_turn_cnt  <= 3'd0;
                    o_dma_grant <= '0;
                    o_cpu_grant <= 1'b0;
                    o_owner_id  <= 3'b000;
                    o_bus_idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb_dma_bus_arbiter
// Drives one arbiter with a single turnaround cycle and one with three from
// the same directed input sequence. A bench-side ownership model predicts
// every output of both instances each cycle; literal expectations pin the
// model at the interesting points of each scenario.

module tb_dma_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] dmaReq;
    logic [3:0] dmaBoundary;
    logic       memWait;

    logic [3:0] grantA, grantB;
    logic       cpuA, cpuB, idleA, idleB, pulseA, pulseB;
    logic [2:0] ownerA, ownerB;

    int checks   = 0;
    int failures = 0;

    // owner: 0..3 channel, -1 CPU, -2 turnaround; idleLeft counts dead cycles still to serve
    typedef struct {
        int owner;
        int idleLeft;
        bit pulse;
    } mstate_t;

    mstate_t modelA, modelB;

    dma_bus_arbiter #(.NUM_CH(4), .TURN_CYCLES(1)) dutA (
        .i_clk(clk), .i_rst(rst), .i_dma_req(dmaReq), .i_dma_boundary(dmaBoundary),
        .i_mem_wait(memWait), .o_dma_grant(grantA), .o_cpu_grant(cpuA), .o_bus_idle(idleA),
        .o_owner_id(ownerA), .o_preempt_pulse(pulseA)
    );

    dma_bus_arbiter #(.NUM_CH(4), .TURN_CYCLES(3)) dutB (
        .i_clk(clk), .i_rst(rst), .i_dma_req(dmaReq), .i_dma_boundary(dmaBoundary),
        .i_mem_wait(memWait), .o_dma_grant(grantB), .o_cpu_grant(cpuB), .o_bus_idle(idleB),
        .o_owner_id(ownerB), .o_preempt_pulse(pulseB)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Next ownership from the arbitration rules: who asked, who may be displaced, and when
    function automatic mstate_t modelStep(mstate_t s, logic rstv, logic [3:0] req,
                                          logic [3:0] bnd, logic wt, int turns);
        mstate_t n = s;
        int lowest = -1;
        bit higherWaiting = 0;
        for (int k = 3; k >= 0; k--) if (req[k]) lowest = k;
        n.pulse = 0;
        if (rstv) begin
            n.owner = -2;
            n.idleLeft = turns;
            return n;
        end
        if (s.owner == -2) begin
            n.idleLeft = s.idleLeft - 1;
            if (n.idleLeft == 0) n.owner = (lowest >= 0) ? lowest : -1;
        end else if (s.owner == -1) begin
            if (lowest >= 0 && !wt) begin
                n.owner = -2;
                n.idleLeft = turns;
            end
        end else if (!wt) begin
            for (int k = 0; k < s.owner; k++) if (req[k]) higherWaiting = 1;
            if (!req[s.owner]) begin
                n.owner = -2;
                n.idleLeft = turns;
            end else if (bnd[s.owner] && higherWaiting) begin
                n.owner = -2;
                n.idleLeft = turns;
                n.pulse = 1;
            end
        end
        return n;
    endfunction

    // Outputs packed as {grant[3:0], cpu, idle, owner_id[2:0], pulse}
    function automatic logic [9:0] modelOut(mstate_t s);
        logic [3:0] g = 4'b0000;
        logic [2:0] id = 3'b000;
        logic c = 1'b0;
        logic i = 1'b0;
        if (s.owner >= 0) begin
            g[s.owner] = 1'b1;
            id = 3'(4 + s.owner);
        end else if (s.owner == -1) begin
            c = 1'b1;
        end else begin
            i = 1'b1;
        end
        return {g, c, i, id, s.pulse};
    endfunction

    // Advance both models on every clock edge from the inputs the DUTs see
    always @(posedge clk) begin
        modelA <= modelStep(modelA, rst, dmaReq, dmaBoundary, memWait, 1);
        modelB <= modelStep(modelB, rst, dmaReq, dmaBoundary, memWait, 3);
    end

    function automatic logic [9:0] dutOut(int inst);
        if (inst == 0) return {grantA, cpuA, idleA, ownerA, pulseA};
        return {grantB, cpuB, idleB, ownerB, pulseB};
    endfunction

    task automatic compareOne(string name, logic [9:0] got, logic [9:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got grant=%b cpu=%b idle=%b id=%b pulse=%b, want grant=%b cpu=%b idle=%b id=%b pulse=%b",
                     name, $time, got[9:6], got[5], got[4], got[3:1], got[0],
                     want[9:6], want[5], want[4], want[3:1], want[0]);
        end
    endtask

    task automatic checkInvariant(string name, logic [9:0] got);
        checks++;
        if ($countones(got[9:6]) + int'(got[5]) + int'(got[4]) != 1) begin
            failures++;
            $display("[TB] FAIL %s at %0t: grant=%b cpu=%b idle=%b, want exactly one owner or idle",
                     name, $time, got[9:6], got[5], got[4]);
        end
    endtask

    // One clock: sample just after the edge, compare both DUTs to the model, then drive new inputs
    task automatic applyStimulus(logic rstv, logic [3:0] req, logic [3:0] bnd, logic wt);
        @(posedge clk);
        #1;
        compareOne("modelA", dutOut(0), modelOut(modelA));
        compareOne("modelB", dutOut(1), modelOut(modelB));
        checkInvariant("onehotA", dutOut(0));
        checkInvariant("onehotB", dutOut(1));
        rst         = rstv;
        dmaReq      = req;
        dmaBoundary = bnd;
        memWait     = wt;
    endtask

    // Hand-computed expectation for one instance (0 = one turn cycle, 1 = three)
    task automatic checkOutput(string name, int inst, logic [3:0] g, logic c, logic i,
                               logic [2:0] id, logic p);
        compareOne(name, dutOut(inst), {g, c, i, id, p});
    endtask

    localparam logic [3:0] NONE = 4'b0000;

    initial begin
        rst = 1'b1;
        dmaReq = NONE;
        dmaBoundary = NONE;
        memWait = 1'b0;

        // Reset release with no requests
        applyStimulus(1, NONE, NONE, 0);
        checkOutput("resetA", 0, 4'b0000, 0, 1, 3'b000, 0);
        checkOutput("resetB", 1, 4'b0000, 0, 1, 3'b000, 0);
        applyStimulus(0, NONE, NONE, 0);
        checkOutput("cycle0IdleA", 0, 4'b0000, 0, 1, 3'b000, 0);
        applyStimulus(0, NONE, NONE, 0);
        checkOutput("cycle1CpuA", 0, 4'b0000, 1, 0, 3'b000, 0);
        checkOutput("cycle1IdleB", 1, 4'b0000, 0, 1, 3'b000, 0);
        applyStimulus(0, NONE, NONE, 0);
        applyStimulus(0, NONE, NONE, 0);
        checkOutput("cpuAfterTurnB", 1, 4'b0000, 1, 0, 3'b000, 0);
        applyStimulus(0, NONE, NONE, 0);
        applyStimulus(0, NONE, NONE, 0);
        checkOutput("cpuStaysA", 0, 4'b0000, 1, 0, 3'b000, 0);

        // CPU to channel 3
        applyStimulus(0, 4'b1000, NONE, 0);
        applyStimulus(0, 4'b1000, NONE, 0);
        checkOutput("cpuDropA", 0, 4'b0000, 0, 1, 3'b000, 0);
        applyStimulus(0, 4'b1000, NONE, 0);
        checkOutput("ch3GrantA", 0, 4'b1000, 0, 0, 3'b111, 0);
        applyStimulus(0, 4'b1000, NONE, 0);
        applyStimulus(0, 4'b1000, NONE, 0);
        checkOutput("ch3GrantB", 1, 4'b1000, 0, 0, 3'b111, 0);
        applyStimulus(0, 4'b1000, NONE, 0);
        applyStimulus(0, 4'b1000, NONE, 0);

        // Channel 0 preempts channel 3 only at its unit boundary
        applyStimulus(0, 4'b1001, NONE, 0);
        applyStimulus(0, 4'b1001, 4'b1000, 0);
        checkOutput("midUnitHoldA", 0, 4'b1000, 0, 0, 3'b111, 0);
        applyStimulus(0, 4'b1001, NONE, 0);
        checkOutput("preemptA", 0, 4'b0000, 0, 1, 3'b000, 1);
        checkOutput("preemptB", 1, 4'b0000, 0, 1, 3'b000, 1);
        applyStimulus(0, 4'b1001, NONE, 0);
        checkOutput("ch0GrantA", 0, 4'b0001, 0, 0, 3'b100, 0);
        applyStimulus(0, 4'b1001, NONE, 0);
        applyStimulus(0, 4'b1001, NONE, 0);
        applyStimulus(0, 4'b1000, NONE, 0);
        applyStimulus(0, 4'b1000, NONE, 0);
        checkOutput("backToTurnA", 0, 4'b0000, 0, 1, 3'b000, 0);
        applyStimulus(0, 4'b1000, NONE, 0);
        checkOutput("ch3RegrantA", 0, 4'b1000, 0, 0, 3'b111, 0);
        applyStimulus(0, 4'b1000, NONE, 0);
        applyStimulus(0, 4'b1000, NONE, 0);
        checkOutput("ch3RegrantB", 1, 4'b1000, 0, 0, 3'b111, 0);

        // Back to CPU, then give the bus to channel 0
        for (int i = 0; i < 5; i++) applyStimulus(0, NONE, NONE, 0);
        checkOutput("cpuAgainB", 1, 4'b0000, 1, 0, 3'b000, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 4'b0001, NONE, 0);
        checkOutput("ch0OwnA", 0, 4'b0001, 0, 0, 3'b100, 0);

        // mem_wait holds the grant even though the request drops
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, NONE, NONE, 1);
            checkOutput("waitHoldA", 0, 4'b0001, 0, 0, 3'b100, 0);
        end
        applyStimulus(0, NONE, NONE, 0);
        checkOutput("waitHoldLastA", 0, 4'b0001, 0, 0, 3'b100, 0);
        applyStimulus(0, NONE, NONE, 0);
        checkOutput("waitReleaseA", 0, 4'b0000, 0, 1, 3'b000, 0);
        applyStimulus(0, NONE, NONE, 0);
        checkOutput("waitCpuA", 0, 4'b0000, 1, 0, 3'b000, 0);

        // Channel 1 owns; lower-priority channel 2 never preempts
        applyStimulus(0, NONE, NONE, 0);
        applyStimulus(0, NONE, NONE, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 4'b0010, NONE, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 4'b0110, 4'b0010, 0);
            checkOutput("noPreemptA", 0, 4'b0010, 0, 0, 3'b101, 0);
            checkOutput("noPreemptB", 1, 4'b0010, 0, 0, 3'b101, 0);
        end
        applyStimulus(0, 4'b0100, NONE, 0);
        applyStimulus(0, 4'b0100, NONE, 0);
        checkOutput("handoverIdleA", 0, 4'b0000, 0, 1, 3'b000, 0);
        checkOutput("turn1B", 1, 4'b0000, 0, 1, 3'b000, 0);
        applyStimulus(0, 4'b0100, NONE, 0);
        checkOutput("ch2GrantA", 0, 4'b0100, 0, 0, 3'b110, 0);
        checkOutput("turn2B", 1, 4'b0000, 0, 1, 3'b000, 0);
        applyStimulus(0, 4'b0100, NONE, 0);
        checkOutput("turn3B", 1, 4'b0000, 0, 1, 3'b000, 0);
        applyStimulus(0, 4'b0100, NONE, 0);
        checkOutput("ch2GrantB", 1, 4'b0100, 0, 0, 3'b110, 0);

        // Reset while channel 2 owns and memory is busy
        applyStimulus(1, 4'b0100, NONE, 1);
        applyStimulus(0, 4'b0100, NONE, 1);
        checkOutput("midResetA", 0, 4'b0000, 0, 1, 3'b000, 0);
        checkOutput("midResetB", 1, 4'b0000, 0, 1, 3'b000, 0);
        applyStimulus(0, 4'b0100, NONE, 0);
        checkOutput("postResetGrantA", 0, 4'b0100, 0, 0, 3'b110, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, NONE, NONE, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
